// File: rtl/counter_seq_pkg.sv
// Shared types for the counter command sequencer:
// opcode and FSM state enums.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH-entry FIFO, first-word-fall-through head.
// Ports: i_clk, i_rst (sync, active high), i_push/i_wdata,
//        i_pop/o_rdata, o_full, o_empty.
module cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_rdata = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Queues LOAD/UP/DOWN/NOP commands and plays them out as
// enable/load/direction strobes for a downstream counter.
// Ports: i_clk, i_rst (sync, active high), i_valid/i_op/i_arg
// command in, o_ready; o_en/o_load/o_dir/o_data counter drive;
// o_done end-of-command pulse; o_busy.
// Macro CMD_SEQ_ABORT_EN adds i_abort and o_aborted.
import counter_seq_pkg::*;

module counter_cmd_seq #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_arg,
  output logic         o_ready,
  output logic         o_en,
  output logic         o_load,
  output logic         o_dir,
  output logic [N-1:0] o_data,
  output logic         o_done,
  output logic         o_busy
`ifdef CMD_SEQ_ABORT_EN
  ,
  input  logic         i_abort,
  output logic         o_aborted
`endif
);

  logic         flush;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [N+1:0] head;
  op_e          head_op;
  logic [N-1:0] head_arg;

  state_e       state;
  state_e       state_n;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_n;
  logic         en_n;
  logic         load_n;
  logic         dir_n;
  logic         done_n;
  logic [N-1:0] data_n;

`ifdef CMD_SEQ_ABORT_EN
  assign flush = i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) o_aborted <= 1'b0;
    else       o_aborted <= i_abort;
  end
`else
  assign flush = 1'b0;
`endif

  assign o_ready  = !full;
  assign push     = i_valid && !full;
  assign head_op  = op_e'(head[N+1:N]);
  assign head_arg = head[N-1:0];
  assign o_busy   = (state != S_IDLE) || !empty;

  // A flush shares the queue's reset, so a command
  // pushed in the abort cycle is dropped as well.
  cmd_fifo #(
    .W     (N + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst || flush),
    .i_push  (push),
    .i_wdata ({i_op, i_arg}),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (full),
    .o_empty (empty)
  );

  // Outputs are computed for the next state and
  // registered with it, so they line up with it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = 1'b0;
    load_n  = 1'b0;
    done_n  = 1'b0;
    dir_n   = o_dir;
    data_n  = o_data;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          unique case (head_op)
            OP_LOAD: begin
              state_n = S_LOAD;
              en_n    = 1'b1;
              load_n  = 1'b1;
              data_n  = head_arg;
            end
            OP_UP, OP_DOWN: begin
              if (head_arg != '0) begin
                state_n = S_RUN;
                cnt_n   = head_arg;
                en_n    = 1'b1;
                dir_n   = (head_op == OP_UP);
              end else begin
                state_n = S_DONE;
                done_n  = 1'b1;
              end
            end
            default: begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_RUN: begin
        // cnt holds the steps left including this one
        if (cnt == N'(1)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - N'(1);
          en_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      o_en   <= 1'b0;
      o_load <= 1'b0;
      o_dir  <= 1'b0;
      o_done <= 1'b0;
      o_data <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      cnt    <= '0;
      o_en   <= 1'b0;
      o_load <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      o_en   <= en_n;
      o_load <= load_n;
      o_dir  <= dir_n;
      o_done <= done_n;
      o_data <= data_n;
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: event scoreboard, counter
// model, vector table and hand-written corner sequences.
module tb_counter_cmd_seq;
  import counter_seq_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         i_clk   = 1'b0;
  logic         i_rst   = 1'b1;
  logic         i_valid = 1'b0;
  logic [1:0]   i_op    = 2'd0;
  logic [N-1:0] i_arg   = '0;
  logic         o_ready, o_en, o_load, o_dir;
  logic         o_done, o_busy;
  logic [N-1:0] o_data;
`ifdef CMD_SEQ_ABORT_EN
  logic         i_abort = 1'b0;
  logic         o_aborted;
`endif

  counter_cmd_seq #(.N(N), .DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_op    (i_op),
    .i_arg   (i_arg),
    .o_ready (o_ready),
    .o_en    (o_en),
    .o_load  (o_load),
    .o_dir   (o_dir),
    .o_data  (o_data),
    .o_done  (o_done),
    .o_busy  (o_busy)
`ifdef CMD_SEQ_ABORT_EN
    ,
    .i_abort   (i_abort),
    .o_aborted (o_aborted)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         en;
    logic         load;
    logic         dir;
    logic         done;
    logic [N-1:0] data;
  } ev_t;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] arg;
    logic [N-1:0] exp_cnt;
  } vec_t;

  ev_t          exp_q[$];
  int           checks  = 0;
  int           passes  = 0;
  int           en_cnt  = 0;
  int           done_cnt = 0;
  logic [N-1:0] cm = '0;
  logic         last_dir  = 1'b0;
  logic [N-1:0] last_data = '0;
  vec_t         vecs[11];

  // downstream counter driven by the DUT outputs
  always @(posedge i_clk) begin
    if (o_en) begin
      if (o_load)     cm <= o_data;
      else if (o_dir) cm <= cm + N'(1);
      else            cm <= cm - N'(1);
    end
  end

  // scoreboard: every en/done cycle must match the queue head
  always @(negedge i_clk) begin
    ev_t act;
    ev_t exp;
    act = {o_en, o_load, o_dir, o_done, o_data};
    if (o_en)   en_cnt++;
    if (o_done) done_cnt++;
    if (o_en || o_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got %h, none expected", act);
      end else begin
        exp = exp_q.pop_front();
        if (act === exp) passes++;
        else $display("FAIL sb_event: got %h want %h", act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic void push_expect(input logic [1:0] op,
                                      input logic [N-1:0] arg);
    if (op == 2'd1) begin
      last_data = arg;
      exp_q.push_back({1'b1, 1'b1, last_dir, 1'b0, last_data});
    end else if (op != 2'd0 && arg != '0) begin
      last_dir = (op == 2'd2);
      for (int k = 0; k < int'(arg); k++)
        exp_q.push_back({1'b1, 1'b0, last_dir, 1'b0, last_data});
    end
    exp_q.push_back({1'b0, 1'b0, last_dir, 1'b1, last_data});
  endfunction

  task automatic send(input logic [1:0] op, input logic [N-1:0] arg,
                      output int waited);
    waited = 0;
    @(negedge i_clk);
    while (!o_ready && waited < 400) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      checks++;
      $display("FAIL send_timeout: ready %b want 1", o_ready);
    end else begin
      i_valid = 1'b1;
      i_op    = op;
      i_arg   = arg;
      push_expect(op, arg);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge i_clk);
    while (o_busy && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    if (o_busy) begin
      checks++;
      $display("FAIL idle_timeout: busy %b want 0", o_busy);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk(nm, {o_en, o_load, o_dir, o_done, o_busy, o_ready, o_data},
        {6'b000001, 8'h00});
  endtask

  initial begin
    int w;
    int be, bd;
    int n_en;

    vecs[0]  = '{2'd2, 8'd3,   8'h5D};
    vecs[1]  = '{2'd3, 8'd0,   8'h5D};
    vecs[2]  = '{2'd0, 8'd0,   8'h5D};
    vecs[3]  = '{2'd3, 8'd5,   8'h58};
    vecs[4]  = '{2'd1, 8'hFE,  8'hFE};
    vecs[5]  = '{2'd2, 8'd3,   8'h01};
    vecs[6]  = '{2'd3, 8'd2,   8'hFF};
    vecs[7]  = '{2'd2, 8'd0,   8'hFF};
    vecs[8]  = '{2'd1, 8'h00,  8'h00};
    vecs[9]  = '{2'd3, 8'd1,   8'hFF};
    vecs[10] = '{2'd2, 8'd255, 8'hFE};

    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_reset_state("reset_state");

    // LOAD 0x5A: exact cycle timing
    send(2'd1, 8'h5A, w);
    @(negedge i_clk);
    chk("c1_en_busy", {o_en, o_busy}, 2'b01);
    @(negedge i_clk);
    chk("c2_load", {o_en, o_load, o_data}, {2'b11, 8'h5A});
    @(negedge i_clk);
    chk("c3_done", {o_done, o_en}, 2'b10);
    @(negedge i_clk);
    chk("c4_busy", o_busy, 0);
    chk("cnt_5a", cm, 8'h5A);

    // one command at a time from the table
    for (int i = 0; i < 11; i++) begin
      be = en_cnt;
      bd = done_cnt;
      if (vecs[i].op == 2'd1)      n_en = 1;
      else if (vecs[i].op == 2'd0) n_en = 0;
      else                         n_en = int'(vecs[i].arg);
      send(vecs[i].op, vecs[i].arg, w);
      wait_idle();
      chk($sformatf("vec%0d_cnt", i), cm, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_en", i), en_cnt - be, n_en);
      chk($sformatf("vec%0d_done", i), done_cnt - bd, 1);
    end

    // back-pressure: UP 10 busy, then five back-to-back
    send(2'd2, 8'd10, w);
    send(2'd1, 8'h10, w);
    send(2'd3, 8'd2, w);
    send(2'd2, 8'd3, w);
    send(2'd0, 8'd0, w);
    chk("full_ready", o_ready, 0);
    i_valid = 1'b1;
    i_op    = 2'd1;
    i_arg   = 8'hEE;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    send(2'd2, 8'd4, w);
    chk("fifth_stalled", w > 0, 1);
    wait_idle();
    chk("bp_cnt", cm, 8'h15);

    // reset mid-RUN of DOWN 10 with two queued
    be = en_cnt;
    send(2'd3, 8'd10, w);
    send(2'd1, 8'h77, w);
    send(2'd2, 8'd5, w);
    w = 0;
    do begin
      @(negedge i_clk);
      #1;
      w++;
    end while (en_cnt - be < 4 && w < 100);
    chk("run_steps", en_cnt - be, 4);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    last_dir  = 1'b0;
    last_data = '0;
    @(negedge i_clk);
    chk("rst_run", {o_en, o_busy, o_ready}, 3'b001);
    chk_reset_state("rst_run_state");
    be = en_cnt;
    bd = done_cnt;
    repeat (20) @(negedge i_clk);
    chk("rst_no_done", done_cnt - bd, 0);
    chk("rst_no_en", en_cnt - be, 0);
    chk("rst_cnt", cm, 8'h11);

`ifdef CMD_SEQ_ABORT_EN
    be = en_cnt;
    send(2'd2, 8'd8, w);
    send(2'd1, 8'h44, w);
    w = 0;
    do begin
      @(negedge i_clk);
      #1;
      w++;
    end while (en_cnt - be < 2 && w < 100);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    chk("abort_now", {o_en, o_done, o_aborted, o_busy, o_ready},
        5'b00101);
    @(negedge i_clk);
    chk("abort_pulse", o_aborted, 0);
    repeat (10) @(negedge i_clk);
    chk("abort_en", en_cnt - be, 2);
    chk("abort_cnt", cm, 8'h13);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk (rising edge), i_rst.
REQ-002 Parameter N, default 8, SHALL set the counter data width.
REQ-003 Parameter DEPTH, default 4, SHALL set the command queue depth; it must be a power of two and at least 2.
REQ-004 i_clk  input  1  clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_valid  input  1  command valid.
REQ-007 i_op  input  2  opcode: NOP=0, LOAD=1, UP=2, DOWN=3.
REQ-008 i_arg  input  N  LOAD value, or step count for UP/DOWN.
REQ-009 o_ready  output  1  queue can accept a command.
REQ-010 o_en, o_load, o_dir  output  1 each  drive the downstream counter's enable, load and direction (1=up) inputs.
REQ-011 o_data  output  N  drives the downstream counter's load-data input.
REQ-012 o_done  output  1  one-cycle pulse marking the end of each command.
REQ-013 o_busy  output  1  high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-014 Accept a command on every cycle where i_valid and o_ready are both 1; o_ready = queue not full; commands presented while o_ready=0 are ignored.
REQ-015 Commands execute strictly in acceptance order; none are lost or duplicated.
REQ-016 FSM states: IDLE, LOAD, RUN, DONE.
REQ-017 IDLE with queue non-empty: pop the head at the edge; go to LOAD (op LOAD), RUN (UP/DOWN with arg>0), or DONE (NOP, or UP/DOWN with arg=0).
REQ-018 LOAD state lasts 1 cycle with o_en=1, o_load=1, o_data=arg; then DONE.
REQ-019 RUN state lasts exactly arg cycles with o_en=1, o_load=0, o_dir=1 for UP and 0 for DOWN; then DONE.
REQ-020 DONE state lasts 1 cycle with o_done=1 and o_en=0; then IDLE.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs; o_ready depends only on queue occupancy.
REQ-022 Latency: a command accepted in cycle c, with the FSM idle and the queue empty, drives its first active cycle at c+2.
REQ-023 Outside LOAD and RUN, o_en=0 and o_load=0; o_data and o_dir hold their last values.
REQ-024 The RUN step counter is N bits; arg=2^N-1 produces exactly 2^N-1 o_en cycles with no wrap.
REQ-025 A push and pop in the same cycle SHALL leave occupancy unchanged; a push when full is impossible by REQ-014.

Reset
REQ-026 i_rst=1 at a clock edge SHALL, from the next cycle: FSM=IDLE, queue empty, o_en=o_load=o_dir=o_done=0, o_data=0, o_busy=0, o_ready=1.
REQ-027 Reset during LOAD/RUN SHALL abandon the command and all queued commands with no further o_en; no o_done is issued for them.

Configuration
REQ-028 Macro CMD_SEQ_ABORT_EN, when defined, SHALL add input i_abort (1 bit) and output o_aborted (1 bit).
REQ-029 With CMD_SEQ_ABORT_EN: i_abort=1 at an edge SHALL flush the queue and send the FSM to IDLE; from the next cycle o_en=0, o_done=0, o_aborted=1 for 1 cycle. A command accepted in that same cycle is discarded. Reset has priority over abort.
REQ-030 Without CMD_SEQ_ABORT_EN: neither port exists and behaviour is per REQ-014..027.

Structure
REQ-031 Package counter_seq_pkg SHALL hold the opcode enum (NOP/LOAD/UP/DOWN) and the FSM state enum.
REQ-032 The queue SHALL be a sub-module cmd_fifo (parameters width, DEPTH; push/pop/full/empty, synchronous active-high reset).

Verification
REQ-033 Reset, then LOAD 0x5A accepted in cycle 0 -> cycle 2: o_en=1, o_load=1, o_data=0x5A; cycle 3: o_done=1; cycle 4: o_busy=0.
REQ-034 UP 3 -> exactly 3 consecutive cycles with o_en=1, o_dir=1, o_load=0, then a single o_done; with a counter model attached, 0x5A becomes 0x5D.
REQ-035 Push 5 commands back-to-back with DEPTH=4 while busy -> o_ready=0 after the 4th is queued; the 5th is accepted only once ready returns; all 5 execute in order.
REQ-036 DOWN 0 and NOP -> each yields one o_done and zero o_en cycles.
REQ-037 i_rst asserted mid-RUN (DOWN 10, after 4 steps) with 2 commands queued -> next cycle o_en=0, o_busy=0, o_ready=1, and no further o_done.
REQ-038 With CMD_SEQ_ABORT_EN, i_abort during RUN of UP 8 -> o_en drops the next cycle, o_aborted pulses once, and the queue is empty.
